cdc_handshake_rx: RTL
=====================

CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

Interface
REQ-001 Parameter WIDTH, default 32: width of transferred data word.
REQ-002 Parameter SYNC_STAGES, default 2, legal range 2..4: synchronizer depth on async_req.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset. clk and rstn are listed first.
REQ-004 Port: clk  input  1  single receive-domain clock.
REQ-005 Port: rstn  input  1  asynchronous active-low reset.
REQ-006 Port: async_req  input  1  4-phase request from the sender domain; asynchronous to clk.
REQ-007 Port: async_data  input  WIDTH  sender data; stable from async_req rise until async_ack is seen high.
REQ-008 Port: async_ack  output  1  4-phase acknowledge to sender; driven directly from a flop.
REQ-009 Port: out_valid  output  1  captured word available.
REQ-010 Port: out_ready  input  1  downstream accepts word.
REQ-011 Port: out_data  output  WIDTH  captured word; stable while out_valid=1.

Function
REQ-012 async_req SHALL pass through a SYNC_STAGES-deep flop chain; only its last stage (req_sync) drives the FSM.
REQ-013 async_data SHALL NOT be synchronized; it is sampled only in the capture step of REQ-015.
REQ-014 FSM states: WAIT_LOW, IDLE, VALID, ACK.
REQ-015 IDLE, req_sync=1 -> VALID: capture async_data into out_data; set out_valid=1 on the same edge.
REQ-016 out_valid SHALL rise SYNC_STAGES+1 clk edges after the first edge that samples async_req high.
REQ-017 VALID, out_ready=1 -> ACK: out_valid=0 and async_ack=1 on the same edge.
REQ-018 VALID, out_ready=0: hold out_valid and out_data unchanged indefinitely.
REQ-019 out_ready already high when out_valid rises: the transfer completes on the next edge, a one-cycle valid.
REQ-020 ACK, req_sync=0 -> IDLE: async_ack=0 on the same edge.
REQ-021 ACK, req_sync=1: hold async_ack=1.
REQ-022 WAIT_LOW, req_sync=0 -> IDLE. This SHALL prevent a request still high across reset from being accepted as new.
REQ-023 At most one word SHALL be in flight. A new request SHALL be accepted only from IDLE, so each req rise yields exactly one out_valid.
REQ-024 out_ready SHALL be ignored outside VALID.
REQ-025 out_data SHALL change only on capture; it holds its last value in other states.

Reset
REQ-026 rstn=0 SHALL asynchronously force: state=WAIT_LOW, async_ack=0, out_valid=0, out_data=0, every synchronizer stage=1.
REQ-027 Reset mid-transfer SHALL discard any uncaptured or unaccepted word. No out_valid may occur until async_req has been seen low and then high again.
REQ-028 Reset release SHALL require no alignment beyond the team's standard reset-synchronizer practice upstream.

Structure
REQ-029 The state enum type (cdc_hs_state_t) SHALL live in shared package cdc_hs_pkg.
REQ-030 The synchronizer SHALL be a sub-module sync_bit with parameters STAGES and RESET_VAL, async active-low reset, and async_reg attributes on its stages.
REQ-031 All outputs SHALL be registered; no combinational path from any input to any output.

Verification (WIDTH=32, SYNC_STAGES=2)
REQ-032 Basic transfer: data=0xDEADBEEF, req rises, out_ready=1 -> out_valid=1 for exactly 1 cycle, 3 edges after req sampled, out_data=0xDEADBEEF. Then ack=1; after req falls, ack=0 within 3 edges.
REQ-033 Backpressure: out_ready=0 for 20 cycles after out_valid -> out_valid and out_data=0x12345678 held and ack=0 throughout. Raise ready -> single accept, ack rises next edge.
REQ-034 Stale request across reset: req=1 held while rstn pulses -> no out_valid. Drop req, then raise again with data 0x0000_00A5 -> exactly one transfer of 0x0000_00A5.
REQ-035 Reset mid-ACK: assert rstn=0 while ack=1 -> ack, out_valid, out_data all 0 immediately, without waiting for a clk edge.
REQ-036 Back-to-back: 100 sender handshakes with random data, random ready gaps and asynchronous sender clock ratio 0.37 -> scoreboard shows 100 words in order, no duplicates or drops.
REQ-037 Data glitch after capture: change async_data while ack=1 -> out_data unaffected.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the 4-phase handshake receiver.
// The FSM state type lives here so monitors and wrappers can decode it.
package cdc_hs_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    VALID    = 2'd2,
    ACK      = 2'd3
  } cdc_hs_state_t;

  function automatic bit sync_stages_legal(input int n);
    return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous control bit.
// Stages carry async_reg so placement keeps them adjacent for MTBF.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  (* async_reg = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      // NOTE: non-blocking assignment keeps each stage one edge behind the previous one.
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Receive side of a 4-phase req/ack crossing: synchronizes req, captures the
// unsynchronized data bus once req is stable, and presents it as valid/ready.
module cdc_handshake_rx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             async_req,
  input  logic [WIDTH-1:0] async_data,
  output logic             async_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_sync_stages
    $error("cdc_handshake_rx: SYNC_STAGES must be in 2..4");
  end

  logic          req_sync;
  cdc_hs_state_t state_q;
  logic          ack_q;
  logic          valid_q;
  logic [WIDTH-1:0] data_q;

  // Stages reset high so a request held across reset looks like "still high"
  // and the FSM waits for it to drop before accepting anything.
  sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_req_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (async_req),
    .q_o  (req_sync)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= WAIT_LOW;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: the data register is reset too, so a discarded word never leaks out after reset.
      data_q  <= '0;
    end else begin
      case (state_q)
        WAIT_LOW: begin
          if (!req_sync) state_q <= IDLE;
        end
        IDLE: begin
          // async_data is guaranteed stable once req_sync is seen high.
          if (req_sync) begin
            state_q <= VALID;
            valid_q <= 1'b1;
            data_q  <= async_data;
          end
        end
        VALID: begin
          if (out_ready) begin
            state_q <= ACK;
            valid_q <= 1'b0;
            ack_q   <= 1'b1;
          end
        end
        ACK: begin
          if (!req_sync) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= WAIT_LOW;
          ack_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign async_ack = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
